// File: rtl/seq_divmod.sv
// Multi-cycle signed divide/modulo: restoring shift-subtract, one quotient bit per clock,
// valid/ready on both request and response sides. C semantics (truncate toward zero).
module seq_divmod #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_dividend,
  input  logic [WIDTH-1:0] in_divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quot,
  output logic [WIDTH-1:0] out_rem,
  output logic             out_div_zero,
  output logic             busy
);

  // state  | meaning
  // IDLE   | waiting for a request, in_ready high
  // RUN    | WIDTH shift-subtract steps on magnitudes
  // FIX    | apply result signs, load output registers
  // DONE   | result presented until out_ready
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sgnq_q, sgnq_d;
  logic             sgnr_q, sgnr_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remo_q, remo_d;
  logic             dz_q, dz_d;
  logic             valid_q, valid_d;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] abs_dvd;
  logic [WIDTH-1:0] abs_dvs;

  // Magnitudes are unsigned, so |INT_MIN| = 2^(WIDTH-1) is representable.
  assign abs_dvd = in_dividend[WIDTH-1] ? (~in_dividend + 1'b1) : in_dividend;
  assign abs_dvs = in_divisor[WIDTH-1]  ? (~in_divisor + 1'b1)  : in_divisor;
  assign rem_sh  = {rem_q, quo_q[WIDTH-1]};
  assign trial   = rem_sh - {1'b0, dvs_q};

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    sgnq_d  = sgnq_q;
    sgnr_d  = sgnr_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    dz_d    = dz_q;
    valid_d = valid_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sgnq_d = in_dividend[WIDTH-1] ^ in_divisor[WIDTH-1];
          sgnr_d = in_dividend[WIDTH-1];
          dvs_d  = abs_dvs;
          if (in_divisor == '0) begin
            quot_d  = '1;
            remo_d  = in_dividend;
            dz_d    = 1'b1;
            valid_d = 1'b1;
            state_d = S_DONE;
          end else begin
            rem_d   = '0;
            quo_d   = abs_dvd;
            cnt_d   = CNT_INIT;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        rem_d = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_LAST) state_d = S_FIX;
      end
      S_FIX: begin
        quot_d  = sgnq_q ? (~quo_q + 1'b1) : quo_q;
        remo_d  = sgnr_q ? (~rem_q + 1'b1) : rem_q;
        dz_d    = 1'b0;
        valid_d = 1'b1;
        state_d = S_DONE;
      end
      default: begin
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      sgnq_q  <= 1'b0;
      sgnr_q  <= 1'b0;
      quot_q  <= '0;
      remo_q  <= '0;
      dz_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      sgnq_q  <= sgnq_d;
      sgnr_q  <= sgnr_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      dz_q    <= dz_d;
      valid_q <= valid_d;
    end
  end

  assign in_ready     = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign out_valid    = valid_q;
  assign out_quot     = quot_q;
  assign out_rem      = remo_q;
  assign out_div_zero = dz_q;

endmodule

// File: tb/tb_seq_divmod.sv
// Bench for seq_divmod: queue-based reference model checked every cycle, plus directed literals.
module tb_seq_divmod;
  logic        clock, reset;
  logic        in_valid, in_ready;
  logic [31:0] in_dividend, in_divisor;
  logic        out_valid, out_ready;
  logic [31:0] out_quot, out_rem;
  logic        out_div_zero, busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  seq_divmod #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_dividend(in_dividend), .in_divisor(in_divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_quot(out_quot), .out_rem(out_rem),
    .out_div_zero(out_div_zero), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: C division semantics from plain signed arithmetic.
  task automatic model(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r, output logic dz);
    int ia, ib;
    ia = a; ib = b;
    dz = 1'b0;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; dz = 1'b1;
    end else if (a == INT_MIN && b == 32'hFFFF_FFFF) begin
      q = INT_MIN; r = 32'd0;
    end else begin
      q = ia / ib; r = ia % ib;
    end
  endtask

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          due;
  } exp_t;
  exp_t eq[$];

  always @(negedge clock) begin
    exp_t e;
    bit idle, exp_v;
    cyc++;
    if (reset) begin
      eq.delete();
    end else begin
      idle  = (eq.size() == 0);
      exp_v = !idle && (cyc >= eq[0].due);
      chk("out_valid", {31'd0, out_valid}, {31'd0, exp_v});
      chk("in_ready", {31'd0, in_ready}, {31'd0, idle});
      chk("busy", {31'd0, busy}, {31'd0, !idle});
      if (exp_v) begin
        chk("model_quot", out_quot, eq[0].q);
        chk("model_rem", out_rem, eq[0].r);
        chk("model_dz", {31'd0, out_div_zero}, {31'd0, eq[0].dz});
        if (out_ready) void'(eq.pop_front());
      end
      if (idle && in_valid) begin
        model(in_dividend, in_divisor, e.q, e.r, e.dz);
        e.due = cyc + (e.dz ? 1 : 34);
        eq.push_back(e);
      end
    end
  end

  task automatic do_req(input logic [31:0] a, input logic [31:0] b, input logic rdy,
                        output logic [31:0] q, output logic [31:0] r,
                        output logic dz, output int lat);
    bit ok;
    @(posedge clock); #1;
    out_ready = rdy;
    in_valid = 1'b1; in_dividend = a; in_divisor = b;
    ok = 0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clock);
      if (in_ready) ok = 1;
    end
    q = 'x; r = 'x; dz = 1'bx; lat = -1;
    if (!ok) begin
      errors++; checks++;
      $display("FAIL accept_timeout: in_ready stayed %b, required 1", in_ready);
    end
    @(posedge clock); #1;
    in_valid = 1'b0; in_dividend = $urandom; in_divisor = $urandom;
    if (ok) begin
      ok = 0;
      for (int n = 1; n <= 100 && !ok; n++) begin
        @(negedge clock);
        if (out_valid) begin ok = 1; lat = n; end
      end
      if (!ok) begin
        errors++; checks++;
        $display("FAIL result_timeout: out_valid stayed %b, required 1", out_valid);
      end
      q = out_quot; r = out_rem; dz = out_div_zero;
    end
  endtask

  task automatic release_after(input int n);
    repeat (n) @(negedge clock);
    @(posedge clock); #1;
    out_ready = 1'b1;
  endtask

  task automatic dir(input string nm, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] eq_, input logic [31:0] er, input logic edz,
                     input int elat);
    logic [31:0] q, r; logic dz; int lat;
    do_req(a, b, 1'b1, q, r, dz, lat);
    chk({nm, "_quot"}, q, eq_);
    chk({nm, "_rem"}, r, er);
    chk({nm, "_dz"}, {31'd0, dz}, {31'd0, edz});
    chk({nm, "_lat"}, lat, elat);
  endtask

  initial begin
    logic [31:0] q, r, a, b; logic dz; int lat;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_dividend = '0; in_divisor = '0;
    repeat (2) @(negedge clock);
    chk("rst_quot", out_quot, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clock); #2 reset = 1'b0;

    dir("d260_13", 32'd260, 32'd13, 32'd20, 32'd0, 1'b0, 34);
    dir("s7_2",    32'd7, 32'd2, 32'd3, 32'd1, 1'b0, 34);
    dir("sm7_2",   -32'sd7, 32'd2, -32'sd3, -32'sd1, 1'b0, 34);
    dir("s7_m2",   32'd7, -32'sd2, -32'sd3, 32'd1, 1'b0, 34);
    dir("sm7_m2",  -32'sd7, -32'sd2, 32'd3, -32'sd1, 1'b0, 34);
    dir("d20_13",  32'd20, 32'd13, 32'd1, 32'd7, 1'b0, 34);
    dir("d7_13",   32'd7, 32'd13, 32'd0, 32'd7, 1'b0, 34);
    dir("dz22",    32'd22, 32'd0, 32'hFFFF_FFFF, 32'd22, 1'b1, 1);
    dir("d22_22",  32'd22, 32'd22, 32'd1, 32'd0, 1'b0, 34);
    dir("min_m1",  INT_MIN, 32'hFFFF_FFFF, INT_MIN, 32'd0, 1'b0, 34);
    dir("min_1",   INT_MIN, 32'd1, INT_MIN, 32'd0, 1'b0, 34);
    dir("max_max", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd1, 32'd0, 1'b0, 34);

    // Backpressure: result must hold for 10 stalled cycles.
    do_req(32'd100, 32'd7, 1'b0, q, r, dz, lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("bp_quot", out_quot, 32'd14);
      chk("bp_rem", out_rem, 32'd2);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clock); #1 out_ready = 1'b1;
    @(negedge clock);
    chk("bp_before_hs", {31'd0, in_ready}, 32'd0);
    @(negedge clock);
    chk("bp_after_hs", {31'd0, in_ready}, 32'd1);
    chk("bp_valid_drop", {31'd0, out_valid}, 32'd0);
    dir("b2b_a", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34);
    dir("b2b_b", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34);

    // Reset in the middle of RUN.
    @(posedge clock); #1;
    in_valid = 1'b1; in_dividend = 32'd1000; in_divisor = 32'd3;
    @(negedge clock);
    chk("mid_accept_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clock); #1 in_valid = 1'b0;
    repeat (14) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("mid_quot", out_quot, 32'd0);
    chk("mid_rem", out_rem, 32'd0);
    chk("mid_dz", {31'd0, out_div_zero}, 32'd0);
    chk("mid_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_busy", {31'd0, busy}, 32'd0);
    @(negedge clock);
    @(posedge clock); #2 reset = 1'b0;
    dir("after_rst", 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 34);

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 9))
        0: begin a = $urandom; b = 32'd0; end
        1: begin a = INT_MIN; b = $urandom_range(0, 3) == 0 ? 32'hFFFF_FFFF : $urandom; end
        2: begin a = $urandom; b = 32'hFFFF_FFFF; end
        3: begin a = $urandom_range(0, 200) - 100; b = $urandom_range(0, 20) - 10; end
        default: begin a = $urandom; b = $urandom >> $urandom_range(0, 31); end
      endcase
      do_req(a, b, 1'($urandom_range(0, 1)), q, r, dz, lat);
      chk("rnd_lat", lat, (b == 32'd0) ? 1 : 34);
      if (!out_ready) release_after($urandom_range(0, 5));
    end

    repeat (5) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
